// File: rtl/ifid_stall_ctrl.sv
// IF/ID pipeline register and stall responder: freezes PC, bubbles ID/EX and stretches multiply stalls to MULT_LAT cycles.
// Stall outputs are combinational (zero latency); IF/ID updates on the next edge. `STALL_PERF_EN adds stall/flush counters.
module ifid_stall_ctrl #(
  parameter int ADDR_RFILE = 5,
  parameter int DATA_W     = 32,
  parameter int MULT_LAT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_ctrl,
  input  logic [1:0]        stall_ctrl_ab,
  input  logic              mult_sel_idex,
  input  logic              flush,
  input  logic [DATA_W-1:0] pc_if,
  input  logic [DATA_W-1:0] instr_if,
  output logic [DATA_W-1:0] pc_ifid,
  output logic [DATA_W-1:0] instr_ifid,
  output logic              valid_ifid,
  output logic              pc_we,
  output logic              idex_bubble,
  output logic [1:0]        hold_ab,
  output logic              stalling
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       flush_count
`endif
);

  typedef enum logic {
    RUN       = 1'b0,
    HOLD_MULT = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT     = 4'(MULT_LAT - 1);
  localparam bit         MULT_STRETCH = (MULT_LAT > 1);

  // Left empty on purpose: marks an out-of-range configuration in the elaborated hierarchy.
  if (ADDR_RFILE < 1 || MULT_LAT < 1 || MULT_LAT > 15) begin : g_param_out_of_range
  end

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] pc_ifid_q, pc_ifid_d;
  logic [DATA_W-1:0] instr_ifid_q, instr_ifid_d;
  logic              valid_ifid_q, valid_ifid_d;
  logic [1:0]        hold_ab_q, hold_ab_d;
  logic              stall_now;
  logic              flush_apply;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (stall_ctrl && mult_sel_idex && MULT_STRETCH) begin
          state_d = HOLD_MULT;
          cnt_d   = CNT_INIT;
        end
      end
      HOLD_MULT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    stall_now   = (state_q == HOLD_MULT) || ((state_q == RUN) && stall_ctrl);
    stalling    = stall_now;
    pc_we       = ~stall_now;
    idex_bubble = stall_now;
  end

  // A branch sitting in a stalled ID has not resolved yet, so flush only counts when not stalling.
  assign flush_apply = flush && !stall_now;

  always_comb begin
    pc_ifid_d    = pc_ifid_q;
    instr_ifid_d = instr_ifid_q;
    valid_ifid_d = valid_ifid_q;
    if (stall_now) begin
      pc_ifid_d    = pc_ifid_q;
    end else if (flush) begin
      pc_ifid_d    = pc_if;
      instr_ifid_d = '0;
      valid_ifid_d = 1'b0;
    end else begin
      pc_ifid_d    = pc_if;
      instr_ifid_d = instr_if;
      valid_ifid_d = 1'b1;
    end
  end

  // hold_ab stays valid through the release cycle so forwarding can select the stalled operand.
  always_comb begin
    hold_ab_d = hold_ab_q;
    if (state_q == RUN) begin
      hold_ab_d = stall_ctrl ? stall_ctrl_ab : 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_ifid_q    <= '0;
      instr_ifid_q <= '0;
      valid_ifid_q <= 1'b0;
      hold_ab_q    <= 2'b00;
    end else begin
      pc_ifid_q    <= pc_ifid_d;
      instr_ifid_q <= instr_ifid_d;
      valid_ifid_q <= valid_ifid_d;
      hold_ab_q    <= hold_ab_d;
    end
  end

  assign pc_ifid    = pc_ifid_q;
  assign instr_ifid = instr_ifid_q;
  assign valid_ifid = valid_ifid_q;
  assign hold_ab    = hold_ab_q;

`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_now && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (flush_apply && (flush_count_q != 16'hFFFF)) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  logic unused_flush_apply;
  assign unused_flush_apply = flush_apply;
`endif

endmodule
